// File: rtl/seqdet_pkg.sv
// Shared types and constants for the bit serializer that feeds the 101 sequence detector.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package seqdet_pkg;

    // Serializer control states: waiting for a word, or presenting its bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int SER_DEFAULT_WIDTH = 20;

    // Bit-counter width: clog2 of the word width, but never narrower than one bit.
    function automatic int ser_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serializer: counts 0..WIDTH-1 within a word.
// Latency: count updates on the edge after clr/inc; last is combinational from count.
// Backpressure: none of its own; the parent withholds inc while stalled.
//
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears count)
//   clr        : force count to 0 on the next edge (wins over inc)
//   inc        : advance count by one on the next edge
//   count      : current bit position
//   last       : count is at WIDTH-1
module ser_bit_counter
    import seqdet_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH,
    parameter int CW    = ser_cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            // Wrap rather than run past the last position, so count can never
            // exceed WIDTH-1 even if the parent over-increments.
            count_d = (count_q == LAST_IDX) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_IDX);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the 101 sequence detector, one bit per cycle.
// Latency: first bit on x the cycle after load is accepted; WIDTH cycles per word, gapless back-to-back.
// Backpressure: stall freezes the current bit; ready only during IDLE or an unstalled last bit.
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset (drops any word in flight)
//   load, din    : load request and the WIDTH-bit word captured when load && ready
//   stall        : downstream hold request
//   ready        : load will be accepted at the next edge
//   x, x_valid   : serial bit and its qualifier
//   done         : the last bit of the word is on x
//
// Build option: define SER_MSB_FIRST_EN to shift left and present din[WIDTH-1] first;
// otherwise din[0] goes first. Timing and handshake are the same either way.
module bit_serializer
    import seqdet_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             stall,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam int            CW       = ser_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic [CW-1:0]    cnt_count;
    logic             cnt_last;

    logic             out_bit;
    logic [WIDTH-1:0] sreg_shift;

`ifdef SER_MSB_FIRST_EN
    assign out_bit    = sreg_q[WIDTH-1];
    assign sreg_shift = sreg_q << 1;
`else
    assign out_bit    = sreg_q[0];
    assign sreg_shift = sreg_q >> 1;
`endif

    ser_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt_count),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        ready   = 1'b0;
        x       = 1'b0;
        x_valid = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    sreg_d  = din;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                x       = out_bit;
                x_valid = 1'b1;
                // done tracks the bit position only, so it holds through a stall.
                done    = (cnt_count == LAST_IDX);
                // Opening ready on the unstalled last bit lets the next word
                // follow with no idle cycle.
                ready   = cnt_last && !stall;
                if (!stall) begin
                    if (cnt_last) begin
                        cnt_clr = 1'b1;
                        if (load) begin
                            sreg_d = din;
                        end else begin
                            sreg_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        sreg_d  = sreg_shift;
                        cnt_inc = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer (WIDTH=20 main instance, WIDTH=1 corner instance).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected serial sequences are written out by hand for both bit orders.
module tb_bit_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [19:0] din;
    logic        stall;
    logic        ready;
    logic        x;
    logic        x_valid;
    logic        done;

    logic        load1;
    logic [0:0]  din1;
    logic        stall1;
    logic        ready1;
    logic        x1;
    logic        x_valid1;
    logic        done1;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [19:0] W1   = 20'b10100101010010101010;
    localparam logic [19:0] W2   = 20'hC0003;   // palindrome: same bits in either order
    localparam logic [19:0] JUNK = 20'hFFFFF;

    // x for cycles 1..20 of W1, cycle 1 in the leftmost position.
`ifdef SER_MSB_FIRST_EN
    logic [19:0] seq1  = 20'b10100101010010101010;
    logic [19:0] yexp1 = 20'b00100001010000101010;
`else
    logic [19:0] seq1  = 20'b01010101001010100101;
    logic [19:0] yexp1 = 20'b00010101000010100001;
`endif

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(20)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (din),
        .stall   (stall),
        .ready   (ready),
        .x       (x),
        .x_valid (x_valid),
        .done    (done)
    );

    bit_serializer #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .load    (load1),
        .din     (din1),
        .stall   (stall1),
        .ready   (ready1),
        .x       (x1),
        .x_valid (x_valid1),
        .done    (done1)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (x !== 1'b0)       begin n_fail++; $display("FAIL reset_x: got %b want 0", x); end
        n_cmp++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL reset_x_valid: got %b want 0", x_valid); end
        n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        next_cycle();
    endtask

    // One word, no stall; also runs the observed bits through a 101 detector model.
    task automatic test_basic_word();
        logic [1:0]  hist;
        logic [19:0] yvec;
        logic        ybit;
        hist = 2'b00;
        yvec = '0;
        load = 1'b1; din = W1; stall = 1'b0;
        next_cycle();
        load = 1'b0; din = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (x !== seq1[19-i])          begin n_fail++; $display("FAIL basic_x[%0d]: got %b want %b", i, x, seq1[19-i]); end
            n_cmp++; if (x_valid !== 1'b1)          begin n_fail++; $display("FAIL basic_x_valid[%0d]: got %b want 1", i, x_valid); end
            n_cmp++; if (done !== (i == 19))        begin n_fail++; $display("FAIL basic_done[%0d]: got %b want %b", i, done, (i == 19)); end
            n_cmp++; if (ready !== (i == 19))       begin n_fail++; $display("FAIL basic_ready[%0d]: got %b want %b", i, ready, (i == 19)); end
            ybit = (hist == 2'b10) && (x === 1'b1);
            hist = {hist[0], x};
            yvec[19-i] = ybit;
            next_cycle();
        end
        @(negedge clk);
        n_cmp++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_x_valid: got %b want 0", x_valid); end
        n_cmp++; if (ready !== 1'b1)   begin n_fail++; $display("FAIL basic_idle_ready: got %b want 1", ready); end
        n_cmp++; if (yvec !== yexp1)   begin n_fail++; $display("FAIL detector_y: got %b want %b", yvec, yexp1); end
        next_cycle();
    endtask

    // Stall for 3 cycles while bit 5 is on x: bit 5 shows for 4 cycles, word ends on cycle 23.
    task automatic test_stall();
        int idx;
        load = 1'b1; din = W1; stall = 1'b0;
        next_cycle();
        load = 1'b0; din = '0;
        for (int c = 1; c <= 23; c++) begin
            stall = (c >= 6 && c <= 8);
            idx = (c <= 6) ? c - 1 : ((c <= 9) ? 5 : c - 4);
            @(negedge clk);
            n_cmp++; if (x !== seq1[19-idx])    begin n_fail++; $display("FAIL stall_x[c%0d]: got %b want %b", c, x, seq1[19-idx]); end
            n_cmp++; if (x_valid !== 1'b1)      begin n_fail++; $display("FAIL stall_x_valid[c%0d]: got %b want 1", c, x_valid); end
            n_cmp++; if (done !== (c == 23))    begin n_fail++; $display("FAIL stall_done[c%0d]: got %b want %b", c, done, (c == 23)); end
            n_cmp++; if (ready !== (c == 23))   begin n_fail++; $display("FAIL stall_ready[c%0d]: got %b want %b", c, ready, (c == 23)); end
            next_cycle();
        end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL stall_idle_x_valid: got %b want 0", x_valid); end
        next_cycle();
    endtask

    // Busy-time load pulse is ignored; load on the last bit chains the next word with no gap.
    task automatic test_back_to_back();
        logic expb;
        load = 1'b1; din = W1; stall = 1'b0;
        next_cycle();
        for (int c = 1; c <= 20; c++) begin
            load = (c == 3 || c == 20);
            din  = (c == 20) ? W2 : JUNK;
            @(negedge clk);
            n_cmp++; if (x !== seq1[20-c])   begin n_fail++; $display("FAIL b2b_w1_x[c%0d]: got %b want %b", c, x, seq1[20-c]); end
            n_cmp++; if (done !== (c == 20)) begin n_fail++; $display("FAIL b2b_w1_done[c%0d]: got %b want %b", c, done, (c == 20)); end
            next_cycle();
        end
        load = 1'b0; din = JUNK;
        for (int k = 0; k < 20; k++) begin
            expb = (k < 2) || (k >= 18);
            @(negedge clk);
            n_cmp++; if (x !== expb)          begin n_fail++; $display("FAIL b2b_w2_x[%0d]: got %b want %b", k, x, expb); end
            n_cmp++; if (x_valid !== 1'b1)    begin n_fail++; $display("FAIL b2b_w2_x_valid[%0d]: got %b want 1", k, x_valid); end
            n_cmp++; if (done !== (k == 19))  begin n_fail++; $display("FAIL b2b_w2_done[%0d]: got %b want %b", k, done, (k == 19)); end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_x_valid: got %b want 0", x_valid); end
        next_cycle();
    endtask

    // Reset (with load and stall also high) while bit 10 is on x, then a clean restart.
    task automatic test_reset_mid_word();
        load = 1'b1; din = W1; stall = 1'b0;
        next_cycle();
        load = 1'b0; din = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_cmp++; if (x !== seq1[20-c]) begin n_fail++; $display("FAIL rst_pre_x[c%0d]: got %b want %b", c, x, seq1[20-c]); end
            next_cycle();
        end
        reset = 1'b1; load = 1'b1; stall = 1'b1; din = JUNK;
        @(negedge clk);
        n_cmp++; if (x !== seq1[9]) begin n_fail++; $display("FAIL rst_bit10_x: got %b want %b", x, seq1[9]); end
        next_cycle();
        reset = 1'b0; load = 1'b0; stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_x_valid: got %b want 0", x_valid); end
        n_cmp++; if (ready !== 1'b1)   begin n_fail++; $display("FAIL rst_after_ready: got %b want 1", ready); end
        n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL rst_after_done: got %b want 0", done); end
        n_cmp++; if (x !== 1'b0)       begin n_fail++; $display("FAIL rst_after_x: got %b want 0", x); end
        next_cycle();
        load = 1'b1; din = W1;
        next_cycle();
        load = 1'b0; din = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (x !== seq1[19-i])   begin n_fail++; $display("FAIL rst_restart_x[%0d]: got %b want %b", i, x, seq1[19-i]); end
            n_cmp++; if (done !== (i == 19)) begin n_fail++; $display("FAIL rst_restart_done[%0d]: got %b want %b", i, done, (i == 19)); end
            next_cycle();
        end
    endtask

    // WIDTH=1: every SHIFT cycle is both first and last bit.
    task automatic test_width1();
        @(negedge clk);
        n_cmp++; if (ready1 !== 1'b1)   begin n_fail++; $display("FAIL w1_idle_ready: got %b want 1", ready1); end
        n_cmp++; if (x_valid1 !== 1'b0) begin n_fail++; $display("FAIL w1_idle_x_valid: got %b want 0", x_valid1); end
        load1 = 1'b1; din1 = 1'b1; stall1 = 1'b0;
        next_cycle();
        load1 = 1'b1; din1 = 1'b0;
        @(negedge clk);
        n_cmp++; if (x1 !== 1'b1)       begin n_fail++; $display("FAIL w1_a_x: got %b want 1", x1); end
        n_cmp++; if (x_valid1 !== 1'b1) begin n_fail++; $display("FAIL w1_a_x_valid: got %b want 1", x_valid1); end
        n_cmp++; if (done1 !== 1'b1)    begin n_fail++; $display("FAIL w1_a_done: got %b want 1", done1); end
        n_cmp++; if (ready1 !== 1'b1)   begin n_fail++; $display("FAIL w1_a_ready: got %b want 1", ready1); end
        next_cycle();
        load1 = 1'b0;
        @(negedge clk);
        n_cmp++; if (x1 !== 1'b0)       begin n_fail++; $display("FAIL w1_b_x: got %b want 0", x1); end
        n_cmp++; if (x_valid1 !== 1'b1) begin n_fail++; $display("FAIL w1_b_x_valid: got %b want 1", x_valid1); end
        n_cmp++; if (done1 !== 1'b1)    begin n_fail++; $display("FAIL w1_b_done: got %b want 1", done1); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (x_valid1 !== 1'b0) begin n_fail++; $display("FAIL w1_end_x_valid: got %b want 0", x_valid1); end
        n_cmp++; if (done1 !== 1'b0)    begin n_fail++; $display("FAIL w1_end_done: got %b want 0", done1); end
        next_cycle();
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; din = '0; stall = 1'b0;
        load1 = 1'b0; din1 = 1'b0; stall1 = 1'b0;
        #1;
        do_reset();
        test_reset();
        test_basic_word();
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
